// File: rtl/gray_ci_pkg.sv
// Shared constants and FSM state type for the RGB565-to-grayscale custom instruction.
package gray_ci_pkg;

   localparam logic [15:0] GRAY_W_R   = 16'd54;
   localparam logic [15:0] GRAY_W_G   = 16'd183;
   localparam logic [15:0] GRAY_W_B   = 16'd19;
   localparam int          NUM_PIXELS = 4;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      DONE
   } state_t;

endpackage

// File: rtl/rgb565_gray_core.sv
// Combinational grayscale conversion of one RGB565 pixel.
module rgb565_gray_core
   import gray_ci_pkg::*;
(
   input  logic [15:0] pixel,
   output logic [7:0]  gray
);

   logic [15:0] sum;

   // Worst case is 13792, so 16 bits never overflow.
   always_comb begin
      sum = {11'd0, pixel[15:11]} * GRAY_W_R
          + {10'd0, pixel[10:5]}  * GRAY_W_G
          + {11'd0, pixel[4:0]}   * GRAY_W_B;
   end

   assign gray = 8'(sum >> 8);

endmodule

// File: rtl/gray4_ci_sequencer.sv
// Custom-instruction unit: four RGB565 pixels to four gray bytes, one pixel per clock
// through a single shared datapath.
module gray4_ci_sequencer
   import gray_ci_pkg::*;
#(
   parameter logic [7:0] customInstructionId = 8'd0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  iseId,
   input  logic [31:0] valueA,
   input  logic [31:0] valueB,
   output logic        done,
   output logic [31:0] result,
   output logic        busy
);

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [63:0] opnd_q, opnd_d;
   logic [31:0] acc_q, acc_d;
   logic        done_q, done_d;
   logic [31:0] result_q, result_d;
   logic        busy_q, busy_d;

   logic [15:0] pix;
   logic [7:0]  gray;

   assign pix = opnd_q[16*cnt_q +: 16];

   rgb565_gray_core u_core (
      .pixel (pix),
      .gray  (gray)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      done_d   = 1'b0;
      result_d = 32'h0;
      busy_d   = busy_q;
      case (state_q)
         IDLE: begin
            if (start && (iseId == customInstructionId)) begin
               opnd_d  = {valueB, valueA};
               acc_d   = 32'h0;
               cnt_d   = 2'd0;
               busy_d  = 1'b1;
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            acc_d[8*cnt_q +: 8] = gray;
            cnt_d = cnt_q + 2'd1;
            // Last pixel: publish the completed word straight into the output register.
            if (cnt_q == 2'(NUM_PIXELS - 1)) begin
               done_d   = 1'b1;
               result_d = acc_d;
               state_d  = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 2'd0;
         opnd_q   <= 64'h0;
         acc_q    <= 32'h0;
         done_q   <= 1'b0;
         result_q <= 32'h0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         done_q   <= done_d;
         result_q <= result_d;
         busy_q   <= busy_d;
      end
   end

   assign done   = done_q;
   assign result = result_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_gray4_ci_sequencer.sv
// Directed plus randomized scoreboard bench for gray4_ci_sequencer.
module tb_gray4_ci_sequencer;

   localparam logic [7:0] ID = 8'h5A;

   logic        clock;
   logic        reset;
   logic        start;
   logic [7:0]  iseId;
   logic [31:0] valueA;
   logic [31:0] valueB;
   logic        done;
   logic [31:0] result;
   logic        busy;

   int          errors = 0;
   int          checks = 0;
   int          m_rem  = 0;
   logic [31:0] sb[$];

   gray4_ci_sequencer #(.customInstructionId(ID)) dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .iseId  (iseId),
      .valueA (valueA),
      .valueB (valueB),
      .done   (done),
      .result (result),
      .busy   (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [7:0] gray_ref(input logic [15:0] p);
      int s;
      s = int'(p[15:11]) * 54 + int'(p[10:5]) * 183 + int'(p[4:0]) * 19;
      return 8'(s / 256);
   endfunction

   function automatic logic [31:0] gray4_ref(input logic [31:0] a, input logic [31:0] b);
      return {gray_ref(b[31:16]), gray_ref(b[15:0]), gray_ref(a[31:16]), gray_ref(a[15:0])};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the reference model at the edge, then check outputs.
   task automatic tick(input logic st, input logic [7:0] id, input logic [31:0] a,
                       input logic [31:0] b, input logic rst, input logic [31:0] exp);
      logic [31:0] e;
      start  = st;
      iseId  = id;
      valueA = a;
      valueB = b;
      reset  = rst;
      @(posedge clock);
      if (rst) begin
         m_rem = 0;
         sb.delete();
      end else if (m_rem > 0) begin
         m_rem--;
      end else if (st && id == ID) begin
         m_rem = 5;
         sb.push_back(exp);
      end
      #1;
      chk("busy", {31'd0, busy}, {31'd0, m_rem > 0});
      if (m_rem == 1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=empty expected=entry");
         end else begin
            e = sb.pop_front();
            chk("done_hi", {31'd0, done}, 32'd1);
            chk("result", result, e);
         end
      end else begin
         chk("done_lo", {31'd0, done}, 32'd0);
         chk("result_zero", result, 32'h0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      start = 0; iseId = 0; valueA = 0; valueB = 0; reset = 1;

      tick(1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 32'h0);
      tick(1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 32'h0);
      idle(10);

      // Mixed colours
      tick(1'b1, ID, 32'hF800FFFF, 32'h001F07E0, 1'b0, 32'h022D0635);
      idle(8);

      // Wrong id is ignored
      tick(1'b1, ID + 8'd1, 32'hF800FFFF, 32'h001F07E0, 1'b0, 32'h0);
      idle(8);

      // Start during busy must not relatch operands
      tick(1'b1, ID, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h35353535);
      idle(1);
      tick(1'b1, ID, 32'h0, 32'h0, 1'b0, 32'h0);
      tick(1'b1, ID + 8'd3, 32'h0, 32'h0, 1'b0, 32'h0);
      idle(6);

      // Reset mid-operation, then a fresh accept
      tick(1'b1, ID, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h35353535);
      idle(2);
      tick(1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 32'h0);
      idle(2);
      tick(1'b1, ID, 32'h0, 32'h0, 1'b0, 32'h00000000);
      idle(7);

      // Back-to-back at the minimum interval
      tick(1'b1, ID, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h35353535);
      idle(5);
      tick(1'b1, ID, 32'hF800F800, 32'hF800F800, 1'b0, 32'h06060606);
      idle(7);

      // Reset and start together: reset wins
      tick(1'b1, ID, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h35353535);
      idle(3);

      // Randomized operands with stray starts while busy
      for (int k = 0; k < 20; k++) begin
         ra = $urandom;
         rb = $urandom;
         tick(1'b1, ID, ra, rb, 1'b0, gray4_ref(ra, rb));
         for (int j = 0; j < 5; j++)
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? ID : 8'h11,
                 $urandom, $urandom, 1'b0, 32'h0);
      end
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gray4_ci_sequencer.md
Name: gray4_ci_sequencer

Overview:
- Multi-cycle custom-instruction unit for the OpenRISC custom-instruction port.
- Converts four packed RGB565 pixels to four 8-bit grayscale bytes: two pixels come from valueA, two from valueB.
- Contains one grayscale datapath and time-shares it across the four pixels, one pixel per clock, under a small FSM.
- Returns the packed 32-bit result with a one-cycle done pulse.

Parameters:
- customInstructionId, 8'd0: iseId value this unit responds to.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  CPU custom-instruction start strobe.
- iseId  in  8  custom-instruction id; the instruction is for this unit only when iseId == customInstructionId.
- valueA  in  32  pixels p0 = valueA[15:0], p1 = valueA[31:16].
- valueB  in  32  pixels p2 = valueB[15:0], p3 = valueB[31:16].
- done  out  1  one-cycle completion pulse.
- result  out  32  {g3, g2, g1, g0}; 32'h0 whenever done = 0.
- busy  out  1  high while an instruction is in flight (CONVERT or DONE).

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, pixel counter = 0, operand registers = 0, byte accumulator = 0.
  - done = 0, result = 32'h0, busy = 0.
- Gray function for one RGB565 pixel p:
  - R = p[15:11], G = p[10:5], B = p[4:0], zero-extended to 16 bits.
  - sum = R*54 + G*183 + B*19, computed at 16 bits. Maximum is 13792, so there is no overflow.
  - gray = sum[15:8].
- FSM states: IDLE, CONVERT, DONE.
- IDLE:
  - Accept condition: start = 1 and iseId == customInstructionId.
  - On accept: latch {valueB, valueA} into a 64-bit operand register, clear the accumulator, set counter = 0, go to CONVERT.
  - start with a non-matching iseId is ignored: no state change, done stays 0.
- CONVERT:
  - Each cycle, the datapath input is pixel[counter] from the operand register (the pixel mux is driven by the counter).
  - gray is written into accumulator byte [8*counter +: 8], and counter increments.
  - When counter == 3, that byte is written and the FSM goes to DONE.
  - CONVERT lasts exactly 4 cycles.
- DONE:
  - done = 1 and result = accumulator (outputs registered) for exactly one cycle, then IDLE.
- Latency:
  - Accepted start in cycle T gives done = 1 in cycle T+5 and nowhere else.
  - busy = 1 for cycles T+1 through T+5.
- start while not in IDLE (CONVERT or DONE), with any iseId: ignored. Operands are not relatched and the in-flight result is unaffected.
- Back-to-back: a start in the cycle after DONE (state back in IDLE) is accepted normally. Minimum issue interval is 6 cycles.
- Inputs may change freely after the accept cycle; only latched operands are used.
- Reset mid-operation (CONVERT or DONE): next cycle is IDLE with all outputs 0. The partial result is discarded and no done pulse is emitted.
- reset and start asserted in the same cycle: reset wins and the start is not accepted.
- result is forced to 32'h0 in all states except DONE.

Decomposition:
- Shared package gray_ci_pkg:
  - Weight constants GRAY_W_R = 54, GRAY_W_G = 183, GRAY_W_B = 19.
  - FSM state typedef {IDLE, CONVERT, DONE}.
  - Pixel-count constant NUM_PIXELS = 4.
- Sub-module rgb565_gray_core: purely combinational; 16-bit pixel in, 8-bit gray out; instantiated once.
- Sequencing, muxing and accumulation stay in gray4_ci_sequencer.

Test Plan:
- Reset, then idle 10 cycles with start = 0 -> done = 0, busy = 0, result = 32'h0 throughout.
- Mixed colours: start = 1, iseId = customInstructionId, valueA = 32'hF800FFFF, valueB = 32'h001F07E0 at T -> done = 1 only at T+5, result = 32'h022D0635 (g0 = 0x35, g1 = 0x06, g2 = 0x2D, g3 = 0x02); busy high T+1..T+5.
- Wrong id: start = 1, iseId = customInstructionId+1, same operands -> no busy, no done, result stays 0 for 8 cycles.
- start during busy: accept operands of all 0xFFFF at T, pulse start with valueA = valueB = 0 at T+2 -> single done at T+5 with result 32'h35353535; no second done.
- Reset mid-operation: accept at T, assert reset at T+3 -> from T+4 busy = 0, done never asserts, result = 0. A new accept at T+6 with all-zero operands -> done at T+11, result 32'h00000000.
- Back-to-back: accept at T (valueA = valueB = 32'hFFFFFFFF) and again at T+6 (valueA = valueB = 32'hF800F800) -> done at T+5 with result 32'h35353535, and done at T+11 with result 32'h06060606.
